// File: rtl/intersection_controller.sv
// Two-road intersection signal controller (main road NS, side road EW) with a
// pedestrian walk phase. NS rests on green and yields to a sensed EW car or a
// latched pedestrian request. Phase lengths are counted in clk cycles. Lamp
// outputs are registered and decoded from the next state, so they change on
// the same edge as the state register.
module intersection_controller #(
  parameter int TW     = 8,   // phase timer width; every duration must be < 2**TW
  parameter int NS_MIN = 20,  // minimum NS green, cycles
  parameter int EW_T   = 16,  // EW green, cycles (fixed)
  parameter int YEL_T  = 4,   // yellow on either road, cycles
  parameter int RED_T  = 2,   // all-red clearance, cycles
  parameter int PED_T  = 10   // pedestrian walk, cycles
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ped_walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  // State codes are visible on the phase output; code 7 is unused and
  // recovers to NS_GRN on the next edge.
  typedef enum logic [2:0] {
    NS_GRN   = 3'd0,
    NS_YEL   = 3'd1,
    RED_A    = 3'd2,
    EW_GRN   = 3'd3,
    EW_YEL   = 3'd4,
    RED_B    = 3'd5,
    PED_WALK = 3'd6
  } state_t;

  // One bit per lamp; each road is one-hot in every legal state.
  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic ped_walk;
  } lamps_t;

  // Last timer value of each phase: a phase of D cycles counts 0..D-1.
  localparam logic [TW-1:0] NS_LAST  = TW'(NS_MIN - 1);
  localparam logic [TW-1:0] EW_LAST  = TW'(EW_T - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YEL_T - 1);
  localparam logic [TW-1:0] RED_LAST = TW'(RED_T - 1);
  localparam logic [TW-1:0] PED_LAST = TW'(PED_T - 1);

  localparam lamps_t RESET_LAMPS = '{ns_green: 1'b1, ew_red: 1'b1, default: 1'b0};

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic [TW-1:0] last;
  logic          done;
  logic          ped_latch;
  lamps_t        lamps_d;
  lamps_t        lamps_q;

  // Select the final timer count of the current phase.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    last = '0;
    case (state)
      NS_GRN:   last = NS_LAST;
      NS_YEL:   last = YEL_LAST;
      RED_A:    last = RED_LAST;
      EW_GRN:   last = EW_LAST;
      EW_YEL:   last = YEL_LAST;
      RED_B:    last = RED_LAST;
      PED_WALK: last = PED_LAST;
      default:  last = '0;
    endcase
  end

  assign done = (timer == last);

  // Next-state decision; a phase can only be left on its done cycle.
  always_comb begin
    next_state = state;
    case (state)
      NS_GRN:   if (done && (ew_car || ped_latch)) next_state = NS_YEL;
      NS_YEL:   if (done) next_state = RED_A;
      RED_A:    if (done) next_state = ped_latch ? PED_WALK : EW_GRN;
      EW_GRN:   if (done) next_state = EW_YEL;
      EW_YEL:   if (done) next_state = RED_B;
      PED_WALK: if (done) next_state = RED_B;
      RED_B:    if (done) next_state = NS_GRN;
      default:  next_state = NS_GRN;
    endcase
  end

  // Lamp pattern for the state about to be entered.
  always_comb begin
    lamps_d = '0;
    case (next_state)
      NS_GRN:   begin lamps_d.ns_green  = 1'b1; lamps_d.ew_red    = 1'b1; end
      NS_YEL:   begin lamps_d.ns_yellow = 1'b1; lamps_d.ew_red    = 1'b1; end
      EW_GRN:   begin lamps_d.ns_red    = 1'b1; lamps_d.ew_green  = 1'b1; end
      EW_YEL:   begin lamps_d.ns_red    = 1'b1; lamps_d.ew_yellow = 1'b1; end
      RED_A,
      RED_B:    begin lamps_d.ns_red    = 1'b1; lamps_d.ew_red    = 1'b1; end
      PED_WALK: begin
        lamps_d.ns_red   = 1'b1;
        lamps_d.ew_red   = 1'b1;
        lamps_d.ped_walk = 1'b1;
      end
      default:  lamps_d = RESET_LAMPS;
    endcase
  end

  // State, phase timer, pedestrian latch and registered lamps.
  // NOTE: reset is asynchronous so the lamps fall back to the safe NS-green pattern without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= NS_GRN;
      timer     <= '0;
      ped_latch <= 1'b0;
      lamps_q   <= RESET_LAMPS;
    end else begin
      // NOTE: non-blocking assignments make every register here see the pre-edge values of the others.
      state   <= next_state;
      lamps_q <= lamps_d;

      // Restart on a state change; a done NS green holds its count while it waits.
      if (next_state != state) begin
        timer <= '0;
      end else if (!done) begin
        timer <= timer + TW'(1);
      end

      // Clearing on entry to the walk phase beats a request on that same edge.
      if (next_state == PED_WALK && state != PED_WALK) begin
        ped_latch <= 1'b0;
      end else if (ped_req) begin
        ped_latch <= 1'b1;
      end
    end
  end

  assign ns_red    = lamps_q.ns_red;
  assign ns_yellow = lamps_q.ns_yellow;
  assign ns_green  = lamps_q.ns_green;
  assign ew_red    = lamps_q.ew_red;
  assign ew_yellow = lamps_q.ew_yellow;
  assign ew_green  = lamps_q.ew_green;
  assign ped_walk  = lamps_q.ped_walk;
  assign ped_wait  = ped_latch;
  assign phase     = state;

endmodule
